// File: rtl/pending_encoder16to4.sv
// rtl/pending_encoder16to4.sv - 16-bit pending request encoder with a 4-bit index handshake output
// Optional macro PENDING_ENC_ROUND_ROBIN_EN: round-robin selection instead of lowest-index-first.
module pending_encoder16to4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  output logic [15:0] pending,
  output logic        overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  sel;
  logic        sel_ok;
  logic        load;
  logic [15:0] load_mask;
  logic [15:0] req_eff;
  logic [15:0] pending_nx;
  logic [3:0]  idx_nx;
  logic        ovf_nx;

  assign sel_ok    = |pending;
  assign out_valid = (state == PRESENT);

`ifdef PENDING_ENC_ROUND_ROBIN_EN
  logic [3:0] rr_ptr;
  logic [3:0] cand;

  // Round-robin pick: first pending bit at or after rr_ptr+1, wrapping past 15.
  always_comb begin
    sel  = 4'd0;
    cand = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      cand = rr_ptr + 4'd1 + i[3:0];
      if (pending[cand]) sel = cand;
    end
  end

  // Pointer remembers the last loaded index; 15 after reset so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= 4'd15;
    else if (load) rr_ptr <= sel;
  end
`else
  // Fixed-priority pick: lowest set pending index wins.
  always_comb begin
    sel = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) sel = i[3:0];
    end
  end
`endif

  // Next-state, load decision and pending/overflow update.
  always_comb begin
    state_nx = state;
    idx_nx   = out_idx;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          load     = 1'b1;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (sel_ok) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) idx_nx = sel;
    load_mask  = load ? (16'h0001 << sel) : 16'h0000;
    req_eff    = en ? req : 16'h0000;
    // A new request on the bit being loaded this edge re-sets it (set wins over clear).
    pending_nx = (pending & ~load_mask) | req_eff;
    // Only a hit on a bit that stays pending is a lost request.
    ovf_nx     = |(req_eff & pending & ~load_mask);
  end

  // State and output registers; reset drops any presented index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_idx  <= 4'd0;
      pending  <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      out_idx  <= idx_nx;
      pending  <= pending_nx;
      overflow <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_pending_encoder16to4.sv
// tb/tb_pending_encoder16to4.sv - randomized self-checking bench for pending_encoder16to4
module tb_pending_encoder16to4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] req = 16'h0000;
  logic        out_ready = 1'b0;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic [15:0] pending;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [15:0] m_pend;
  bit          m_valid;
  int          m_idx;
  bit          m_ovf;
  int          m_last;

  pending_encoder16to4 dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .out_ready(out_ready),
    .out_idx(out_idx), .out_valid(out_valid), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_update(input bit r, input bit e, input logic [15:0] q, input bit rd);
    int pick;
    int start;
    int cand;
    bit take;
    logic [15:0] newreq;
    if (r) begin
      m_pend = 16'h0; m_valid = 0; m_idx = 0; m_ovf = 0; m_last = 15;
      return;
    end
    pick = -1;
    take = !m_valid || rd;
`ifdef PENDING_ENC_ROUND_ROBIN_EN
    start = (m_last + 1) % 16;
`else
    start = 0;
`endif
    if (take) begin
      for (int k = 0; k < 16; k++) begin
        cand = (start + k) % 16;
        if (pick < 0 && m_pend[cand]) pick = cand;
      end
    end
    newreq = e ? q : 16'h0;
    m_ovf = 0;
    for (int b = 0; b < 16; b++)
      if (newreq[b] && m_pend[b] && b != pick) m_ovf = 1;
    if (pick >= 0) m_pend[pick] = 1'b0;
    m_pend = m_pend | newreq;
    if (pick >= 0) begin
      m_valid = 1; m_idx = pick; m_last = pick;
    end else if (take) begin
      m_valid = 0; m_idx = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [15:0] q, input bit rd);
    rst = r; en = e; req = q; out_ready = rd;
    @(posedge clk);
    #1;
    model_update(r, e, q, rd);
    check("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
    check("out_idx", {12'd0, out_idx}, m_idx[15:0]);
    check("pending", pending, m_pend);
    check("overflow", {15'd0, overflow}, {15'd0, m_ovf});
  endtask

  initial begin
    // Reset, then requests ignored while disabled
    step(1, 0, 16'h0, 0);
    check("reset_valid", {15'd0, out_valid}, 16'd0);
    check("reset_pending", pending, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'hFFFF, 0);
      check("en0_pending", pending, 16'h0);
      check("en0_valid", {15'd0, out_valid}, 16'd0);
    end

    // Single request latency and return to idle
    step(0, 1, 16'h0400, 1);
    check("single_pend", pending, 16'h0400);
    step(0, 0, 16'h0, 1);
    check("single_valid", {15'd0, out_valid}, 16'd1);
    check("single_idx", {12'd0, out_idx}, 16'd10);
    check("single_pend0", pending, 16'h0);
    step(0, 0, 16'h0, 1);
    check("single_idle", {15'd0, out_valid}, 16'd0);

    // Priority order with stall
    step(0, 1, 16'h8421, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'h0, 0);
      check("stall_idx", {12'd0, out_idx}, 16'd0);
    end
    step(0, 0, 16'h0, 1);
    check("seq_idx5", {12'd0, out_idx}, 16'd5);
    step(0, 0, 16'h0, 1);
    check("seq_idx10", {12'd0, out_idx}, 16'd10);
    step(0, 0, 16'h0, 1);
    check("seq_idx15", {12'd0, out_idx}, 16'd15);
    step(0, 0, 16'h0, 1);
    check("seq_idle", {15'd0, out_valid}, 16'd0);

    // Overflow only on a third request of a still-pending bit
    step(0, 1, 16'h0010, 0);
    step(0, 1, 16'h0010, 0);
    check("ovf_idx4", {12'd0, out_idx}, 16'd4);
    check("ovf_none1", {15'd0, overflow}, 16'd0);
    check("ovf_pend4", pending, 16'h0010);
    step(0, 1, 16'h0010, 0);
    check("ovf_pulse", {15'd0, overflow}, 16'd1);
    step(0, 0, 16'h0, 0);
    check("ovf_drop", {15'd0, overflow}, 16'd0);

    // Reset while presenting
    step(1, 0, 16'h0, 0);
    step(0, 1, 16'h0080, 0);
    step(0, 1, 16'h0300, 0);
    check("pre_rst_idx", {12'd0, out_idx}, 16'd7);
    check("pre_rst_pend", pending, 16'h0300);
    step(1, 1, 16'hFFFF, 1);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_idx", {12'd0, out_idx}, 16'd0);
    check("rst_pend", pending, 16'h0);

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    // Round-robin alternation
    step(0, 1, 16'h0003, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0003, 1);
      check("rr_alt", {12'd0, out_idx}, (i % 2 == 0) ? 16'd0 : 16'd1);
    end
`endif

    // Randomized traffic against the model
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom() & $urandom() & $urandom()), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
